// File: rtl/scan_chain_loader_if.sv
// scan_chain_loader_if: host word/readback handshake and scan-chain pins of the loader.
interface scan_chain_loader_if #(
   parameter int WORD_WIDTH = 8
);
   logic                  start, in_valid, in_ready, scan_en, scan_in, scan_out, rd_valid, busy, done;
   logic [WORD_WIDTH-1:0] in_data, rd_data;
   modport master (
      output start, in_valid, in_data, scan_out,
      input  in_ready, scan_en, scan_in, rd_valid, rd_data, busy, done
   );
   modport slave (
      input  start, in_valid, in_data, scan_out,
      output in_ready, scan_en, scan_in, rd_valid, rd_data, busy, done
   );
endinterface

// File: rtl/scan_chain_loader.sv
// scan_chain_loader: serializes host words MSB-first into a scan chain and returns the displaced tail bits as readback words.
module scan_chain_loader #(
   parameter int CHAIN_LEN  = 16,
   parameter int WORD_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(CHAIN_LEN+1)
) (
   input logic               clk,
   input logic               rst_n,
   scan_chain_loader_if.slave bus
);
   localparam int WB_WIDTH = $clog2(WORD_WIDTH+1);
   typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;
   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  rem_q, rem_d;
   logic [WB_WIDTH-1:0]   bits_q, bits_d, len_q, len_d;
   logic [WORD_WIDTH-1:0] tx_q, tx_d, rb_q, rb_d, rd_data_q, rd_data_d, rb_next;
   logic                  rd_valid_q, rd_valid_d;
   assign rb_next = WORD_WIDTH'({rb_q, bus.scan_out});
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      bits_d     = bits_q;
      len_d      = len_q;
      tx_d       = tx_q;
      rb_d       = rb_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (state_q == IDLE && bus.start) begin
         state_d = WAIT_WORD;
         rem_d   = CNT_WIDTH'(CHAIN_LEN);
      end
      if (state_q == WAIT_WORD && bus.in_valid) begin
         tx_d    = bus.in_data;
         bits_d  = (32'(rem_q) >= WORD_WIDTH) ? WB_WIDTH'(WORD_WIDTH) : WB_WIDTH'(rem_q);
         len_d   = bits_d;
         rb_d    = '0;
         state_d = SHIFT;
      end
      if (state_q == SHIFT) begin
         tx_d   = tx_q << 1;
         rb_d   = rb_next;
         bits_d = bits_q - WB_WIDTH'(1);
         rem_d  = rem_q - CNT_WIDTH'(1);
         if (bits_q == WB_WIDTH'(1)) begin
            state_d    = (rem_q == CNT_WIDTH'(1)) ? DONE : WAIT_WORD;
            rd_valid_d = 1'b1;
            // a short final word is left-aligned so the first captured bit stays in the MSB
            rd_data_d  = rb_next << (WORD_WIDTH - 32'(len_q));
         end
      end
      if (state_q == DONE) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         bits_q     <= '0;
         len_q      <= '0;
         tx_q       <= '0;
         rb_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         bits_q     <= bits_d;
         len_q      <= len_d;
         tx_q       <= tx_d;
         rb_q       <= rb_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end
   assign bus.in_ready = state_q == WAIT_WORD;
   assign bus.scan_en  = state_q == SHIFT;
   assign bus.scan_in  = (state_q == SHIFT) & tx_q[WORD_WIDTH-1];
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.busy     = state_q != IDLE;
   assign bus.done     = state_q == DONE;
endmodule

// File: tb/tb_scan_chain_loader.sv
// tb_scan_chain_loader: drives a 16-bit and a 12-bit loader into behavioural SRAM chains and checks image and readback.
module tb_scan_chain_loader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_v [2], in_valid_v [2];
   logic [7:0]  in_data_v [2];
   logic        in_ready_w [2], scan_en_w [2], scan_in_w [2], rd_valid_w [2], busy_w [2], done_w [2];
   logic [7:0]  rd_data_w [2];
   logic [15:0] chain [2] = '{default: '0};
   logic [15:0] img [2];
   int          n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   scan_chain_loader_if #(.WORD_WIDTH(8)) b0 ();
   scan_chain_loader_if #(.WORD_WIDTH(8)) b1 ();
   scan_chain_loader #(.CHAIN_LEN(16), .WORD_WIDTH(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   scan_chain_loader #(.CHAIN_LEN(12), .WORD_WIDTH(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   assign b0.start = start_v[0];
   assign b0.in_valid = in_valid_v[0];
   assign b0.in_data = in_data_v[0];
   assign b0.scan_out = chain[0][15];
   assign b1.start = start_v[1];
   assign b1.in_valid = in_valid_v[1];
   assign b1.in_data = in_data_v[1];
   assign b1.scan_out = chain[1][11];
   assign in_ready_w = '{b0.in_ready, b1.in_ready};
   assign scan_en_w  = '{b0.scan_en, b1.scan_en};
   assign scan_in_w  = '{b0.scan_in, b1.scan_in};
   assign rd_valid_w = '{b0.rd_valid, b1.rd_valid};
   assign busy_w     = '{b0.busy, b1.busy};
   assign done_w     = '{b0.done, b1.done};
   assign rd_data_w  = '{b0.rd_data, b1.rd_data};
   // SRAM cells: index 0 is the head, the top index is the tail
   always @(posedge clk) begin
      if (scan_en_w[0]) chain[0] <= {chain[0][14:0], scan_in_w[0]};
      if (scan_en_w[1]) chain[1] <= {4'b0, chain[1][10:0], scan_in_w[1]};
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_zero(input int i);
      check("rst_in_ready", 32'(in_ready_w[i]), 0);
      check("rst_scan_en", 32'(scan_en_w[i]), 0);
      check("rst_scan_in", 32'(scan_in_w[i]), 0);
      check("rst_rd_valid", 32'(rd_valid_w[i]), 0);
      check("rst_rd_data", 32'(rd_data_w[i]), 0);
      check("rst_busy", 32'(busy_w[i]), 0);
      check("rst_done", 32'(done_w[i]), 0);
   endtask
   task automatic run_pass(input int i, input logic [7:0] w0, input logic [7:0] w1, input int stall, input bit spur);
      int          len, se, rb, wi, st, cyc;
      bit          fin, acc;
      logic [15:0] ws, new_img, ob, snap;
      logic [7:0]  exp_rb [2], wv [2];
      len = (i == 1) ? 12 : 16;
      ws = {w0, w1};
      wv[0] = w0;
      wv[1] = w1;
      new_img = ws >> (16 - len);
      ob = img[i] << (16 - len);
      exp_rb[0] = ob[15:8];
      exp_rb[1] = ob[7:0];
      se = 0; rb = 0; wi = 0; st = 0; cyc = 0; fin = 0; acc = 0; snap = '0;
      @(negedge clk);
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      check("busy_after_start", 32'(busy_w[i]), 1);
      while (!fin && cyc < 300) begin
         if (acc) check("accept_to_scan_en", 32'(scan_en_w[i]), 1);
         acc = 0;
         if (scan_en_w[i]) se++;
         if (rd_valid_w[i]) begin
            if (rb < 2) check("rd_data", 32'(rd_data_w[i]), 32'(exp_rb[rb]));
            rb++;
         end
         if (done_w[i]) fin = 1;
         start_v[i] = spur && scan_en_w[i];
         in_valid_v[i] = 1'b0;
         if (in_ready_w[i] && wi < 2) begin
            if (st > 0) begin
               if (st == stall) snap = chain[i];
               else check("stall_chain", 32'(chain[i]), 32'(snap));
               check("stall_scan_en", 32'(scan_en_w[i]), 0);
               st--;
            end else begin
               in_valid_v[i] = 1'b1;
               in_data_v[i] = wv[wi];
               wi++;
               st = stall;
               acc = 1;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start_v[i] = 1'b0;
      in_valid_v[i] = 1'b0;
      check("pass_done", 32'(fin), 1);
      check("done_single", 32'(done_w[i]), 0);
      check("busy_after_done", 32'(busy_w[i]), 0);
      check("scan_en_cycles", 32'(se), 32'(len));
      check("rd_pulses", 32'(rb), 2);
      check("chain_image", 32'(chain[i]), 32'(new_img));
      img[i] = new_img;
   endtask
   task automatic reset_mid(input logic [7:0] wv);
      int          se, cyc;
      logic [15:0] old;
      se = 0;
      cyc = 0;
      old = img[0];
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      in_valid_v[0] = 1'b1;
      in_data_v[0] = wv;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      while (cyc < 50) begin
         if (scan_en_w[0]) se++;
         if (se == 3) break;
         @(negedge clk);
         cyc++;
      end
      check("reset_reach_shift", 32'(se), 3);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero(0);
      rst_n = 1'b1;
      img[0] = (old << 3) | 16'(wv >> 5);
      check("chain_after_reset", 32'(chain[0]), 32'(img[0]));
      @(negedge clk);
      check("idle_after_reset", 32'(busy_w[0]), 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0;
         in_valid_v[i] = 1'b0;
         in_data_v[i] = '0;
         img[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero(0);
      chk_zero(1);
      rst_n = 1'b1;
      in_valid_v[0] = 1'b1;
      in_data_v[0] = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         check("idle_in_ready", 32'(in_ready_w[0]), 0);
         check("idle_busy", 32'(busy_w[0]), 0);
      end
      in_valid_v[0] = 1'b0;
      check("idle_chain", 32'(chain[0]), 0);
      run_pass(0, 8'hA5, 8'h3C, 0, 0);
      check("sram_a53c", 32'(chain[0]), 32'h0000A53C);
      run_pass(0, 8'hFF, 8'h00, 0, 0);
      check("sram_ff00", 32'(chain[0]), 32'h0000FF00);
      run_pass(0, 8'hA5, 8'h3C, 5, 0);
      check("sram_stall_a53c", 32'(chain[0]), 32'h0000A53C);
      run_pass(1, 8'hC3, 8'hB7, 0, 0);
      check("sram_c3b", 32'(chain[1]), 32'h00000C3B);
      run_pass(1, 8'h5A, 8'h00, 0, 1);
      reset_mid(8'hE6);
      run_pass(0, 8'h12, 8'h34, 1, 1);
      for (int r = 0; r < 10; r++)
         run_pass(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Serial configuration writer for the FPGA fabric's scan-chained SRAM cells.
- Accepts a configuration bitstream as parallel words from the host/config port, serializes it onto `scan_in`, and drives `scan_en`.
- Captures the bits displaced from the chain tail (`scan_out`) and returns them as readback words. One load pass therefore also verifies the previous configuration.

Parameters:
- CHAIN_LEN, 16, total scan-chain length in bits; must be ≥ 1. Default matches one 16-cell SRAM.
- WORD_WIDTH, 8, width of the host input word and readback word; must be ≥ 1.
- CNT_WIDTH, $clog2(CHAIN_LEN+1), width of the remaining-bit counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a full-chain load; sampled in IDLE only.
- in_valid  input  1  host word valid.
- in_data  input  WORD_WIDTH  host word; bits are sent MSB first.
- in_ready  output  1  loader can accept a word this cycle.
- scan_en  output  1  chain shift enable, to the SRAM `scan_en`.
- scan_in  output  1  serial data into the chain head.
- scan_out  input  1  serial data from the chain tail.
- rd_valid  output  1  one-cycle pulse; `rd_data` is valid.
- rd_data  output  WORD_WIDTH  readback word, first-captured bit in the MSB.
- busy  output  1  high from the cycle after `start` is accepted until DONE is exited.
- done  output  1  one-cycle pulse when all CHAIN_LEN bits have been shifted.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State → IDLE.
  - All outputs 0: in_ready, scan_en, scan_in, rd_valid, rd_data, busy, done.
  - Remaining counter → 0.
  - Reset mid-shift abandons the pass immediately; scan_en is 0 the next cycle. The chain holds whatever partial contents it has.
- Outputs are driven directly from registers (state and shift register). No combinational path from inputs to outputs.
- FSM states: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - When start=1: remaining ← CHAIN_LEN, go to WAIT_WORD.
  - in_valid is ignored in IDLE.
- WAIT_WORD:
  - in_ready=1, scan_en=0, busy=1.
  - The chain is frozen here; stalls of any length are safe.
  - On in_valid & in_ready:
    - tx_sr ← in_data.
    - word_bits ← min(WORD_WIDTH, remaining).
    - rb_sr ← 0.
    - Go to SHIFT.
- SHIFT:
  - in_ready=0, scan_en=1, scan_in=tx_sr[MSB].
  - Each posedge:
    - tx_sr shifts left (zero fill).
    - rb_sr ← {rb_sr[WORD_WIDTH-2:0], scan_out}. This captures the pre-edge chain tail, the same edge the chain shifts.
    - word_bits and remaining decrement.
  - When the final bit of the word is shifted: go to WAIT_WORD if remaining becomes nonzero, else DONE.
  - On that transition, rd_valid=1 for one cycle. rd_data = captured bits, first-captured in the MSB.
  - A partial last word is left-aligned, with the low (WORD_WIDTH − bits) bits zero.
- Partial last word: when CHAIN_LEN is not a multiple of WORD_WIDTH, only the upper `remaining` bits of the last host word are sent. Its low bits are discarded.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - start in DONE is ignored.
- start while busy is ignored, with no effect on the pass in flight.
- Latency:
  - Word accept edge → scan_en high the next cycle.
  - scan_en stays high for exactly word_bits consecutive cycles per word.
  - A full pass with zero stall takes ceil(CHAIN_LEN/WORD_WIDTH)·(1+WORD_WIDTH) + 2 cycles from start, approximately.
- Bit ordering result: after a pass, the first bit sent sits at chain index CHAIN_LEN−1 (the tail). The last bit sent sits at index 0.
- rd_data has no backpressure; the host must sample it on the rd_valid pulse.
- scan_en is never high outside SHIFT. The SRAM `we` path must not be asserted while busy=1; that is the integrator's rule, not checked here.

Test Plan:
- Full load, CHAIN_LEN=16, WORD_WIDTH=8, loader driving a 16-cell SRAM preloaded with 0x0000:
  - Stimulus: start, then words 0xA5 and 0x3C.
  - Required: sram_data=0xA53C.
  - Required: two rd_valid pulses, each with rd_data=0x00.
  - Required: done pulses once; scan_en is high for 16 cycles total.
- Readback: repeat the previous load with words 0xFF, 0x00.
  - Required: rd_data=0xA5 then 0x3C.
  - Required: final sram_data=0xFF00.
- Host stall: insert 5 idle cycles between words.
  - Required: scan_en stays 0 and the chain is unchanged during the stall.
  - Required: the final contents are identical to the no-stall case.
- Partial word, CHAIN_LEN=12:
  - Stimulus: words 0xC3, 0xB7.
  - Required: second word shifts only 4 bits (0xB).
  - Required: chain = 0xC3B.
  - Required: second rd_data is left-aligned with low nibble 0.
- Reset mid-SHIFT (after 3 bits of the first word):
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Required: a subsequent start performs a clean full pass.
- Spurious inputs:
  - in_valid in IDLE → no acceptance.
  - start during SHIFT → ignored, with exactly one done pulse for the pass.
